// File: rtl/btn_conditioner_pkg.sv
// Shared debounce state encoding, defaults and key-code constants for the
// pushbutton conditioner.
package btn_conditioner_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED    = 2'd0,
      ST_DEB_PRESS   = 2'd1,
      ST_PRESSED     = 2'd2,
      ST_DEB_RELEASE = 2'd3
   } deb_state_e;

   localparam int DEB_CYCLES_DEF = 1000000;
   localparam int CNT_W_DEF      = 20;

   localparam logic [1:0] KEY_BTN0 = 2'd0;
   localparam logic [1:0] KEY_BTN1 = 2'd1;
   localparam logic [1:0] KEY_BTN2 = 2'd2;
   localparam logic [1:0] KEY_BTN3 = 2'd3;

   function automatic logic [1:0] key_code_of(input int idx);
      case (idx)
         32'sd0:  return KEY_BTN0;
         32'sd1:  return KEY_BTN1;
         32'sd2:  return KEY_BTN2;
         32'sd3:  return KEY_BTN3;
         default: return KEY_BTN0;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: two-flop synchroniser feeding a four-state debounce
// FSM that reports the accepted level and a one-cycle press pulse.
module btn_debounce_ch
   import btn_conditioner_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic held,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             s1_r;
   logic             s2_r;
   logic             press_r;
   logic [CNT_W-1:0] cnt_r;
   deb_state_e       state_r;

   // Synchroniser, debounce FSM and stability counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r    <= 1'b0;
         s2_r    <= 1'b0;
         press_r <= 1'b0;
         cnt_r   <= CNT_ZERO;
         state_r <= ST_RELEASED;
      end else begin
         s1_r    <= raw;
         s2_r    <= s1_r;
         press_r <= 1'b0;
         case (state_r)
            ST_RELEASED: begin
               if (s2_r) begin
                  state_r <= ST_DEB_PRESS;
                  cnt_r   <= CNT_ONE;
               end else begin
                  cnt_r   <= CNT_ZERO;
               end
            end
            ST_DEB_PRESS: begin
               if (!s2_r) begin
                  state_r <= ST_RELEASED;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= ST_PRESSED;
                  cnt_r   <= CNT_ZERO;
                  press_r <= 1'b1;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
               end
            end
            ST_PRESSED: begin
               if (!s2_r) begin
                  state_r <= ST_DEB_RELEASE;
                  cnt_r   <= CNT_ONE;
               end else begin
                  cnt_r   <= CNT_ZERO;
               end
            end
            ST_DEB_RELEASE: begin
               if (s2_r) begin
                  state_r <= ST_PRESSED;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= ST_RELEASED;
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= ST_RELEASED;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

   // The button still counts as held while its release is being qualified.
   assign held  = (state_r == ST_PRESSED) || (state_r == ST_DEB_RELEASE);
   assign press = press_r;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw pushbuttons into debounced levels, one-shot press
// strobes and a single-key encoder with valid/error flags.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             BtnCond_CLK,
   input  logic             BtnCond_RST,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_held,
   output logic [N_BTN-1:0] btn_press,
   output logic             key_valid,
   output logic [1:0]       key_code,
   output logic             key_err
);

   localparam int              PC_W   = $clog2(N_BTN + 1);
   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   logic [N_BTN-1:0] ch_held_s;
   logic [N_BTN-1:0] ch_press_s;
   logic [PC_W-1:0]  press_cnt_s;
   logic [1:0]       press_idx_s;
   logic             other_held_s;
   logic             valid_s;
   logic             err_s;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEB_CYCLES (DEB_CYCLES),
         .CNT_W      (CNT_W)
      ) u_ch (
         .clk   (BtnCond_CLK),
         .rst   (BtnCond_RST),
         .raw   (btn_raw[g]),
         .held  (ch_held_s[g]),
         .press (ch_press_s[g])
      );
   end

   // Classify this cycle's new presses against buttons already held.
   always_comb begin
      press_cnt_s = {PC_W{1'b0}};
      press_idx_s = KEY_BTN0;
      for (int i = 0; i < N_BTN; i++) begin
         press_cnt_s = press_cnt_s + PC_W'(ch_press_s[i]);
         press_idx_s = ch_press_s[i] ? key_code_of(i) : press_idx_s;
      end
      other_held_s = |(btn_held & ~ch_press_s);
      valid_s      = (press_cnt_s == PC_ONE) && !other_held_s;
      err_s        = (press_cnt_s > PC_ONE) || ((press_cnt_s == PC_ONE) && other_held_s);
   end

   // Output register stage; key_code only moves on a clean single press.
   always_ff @(posedge BtnCond_CLK) begin
      if (BtnCond_RST) begin
         btn_held  <= {N_BTN{1'b0}};
         btn_press <= {N_BTN{1'b0}};
         key_valid <= 1'b0;
         key_err   <= 1'b0;
         key_code  <= KEY_BTN0;
      end else begin
         btn_held  <= ch_held_s;
         btn_press <= ch_press_s;
         key_valid <= valid_s;
         key_err   <= err_s;
         key_code  <= valid_s ? press_idx_s : key_code;
      end
   end

endmodule
